// File: rtl/ball_shot_engine_if.sv
// Request/response bundle between the game controller and the ball shot engine.
// The controller side (master) issues shot, arrival and keeper requests; the
// engine side (slave) returns ball position, status and the shot result.
interface ball_shot_engine_if #(
    parameter int DIR_W = 3
);
    logic             shoot_valid;
    logic [DIR_W-1:0] shoot_dir;
    logic             shoot_ready;
    logic             player_at_ball;
    logic             keeper_valid;
    logic [DIR_W-1:0] keeper_dir;
    logic [9:0]       BallX;
    logic [9:0]       BallY;
    logic [9:0]       BallS;
    logic             busy;
    logic             result_valid;
    logic             result_save;
    logic [DIR_W-1:0] result_dir;

    modport master (
        output shoot_valid, shoot_dir, player_at_ball, keeper_valid, keeper_dir,
        input  shoot_ready, BallX, BallY, BallS, busy, result_valid, result_save, result_dir
    );

    modport slave (
        input  shoot_valid, shoot_dir, player_at_ball, keeper_valid, keeper_dir,
        output shoot_ready, BallX, BallY, BallS, busy, result_valid, result_save, result_dir
    );
endinterface

// File: rtl/ball_shot_engine.sv
// Penalty-shot ball engine: accepts a shot, waits for the shooter to reach the
// ball, flies the ball towards the goal line one step per frame in fixed point,
// latches the first keeper dive and reports save/goal on arrival.
module ball_shot_engine #(
    parameter int NUM_DIRS     = 5,
    parameter int FRAC_BITS    = 4,
    parameter int BALL_X0      = 320,
    parameter int BALL_Y0      = 365,
    parameter int GOAL_Y       = 100,
    parameter int Y_STEP       = 2,
    parameter int BALL_SIZE    = 16,
    parameter int X_STEP_UNIT  = 16,
    parameter int HOLD_FRAMES  = 30,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic                frame_clk,
    input  logic                Reset_n,
    ball_shot_engine_if.slave   bus
);
    localparam int DIR_W  = $clog2(NUM_DIRS);
    localparam int PW     = 10 + FRAC_BITS;   // position register width
    localparam int XW     = FRAC_BITS + 11;   // signed lateral arithmetic width
    localparam int CENTER = (NUM_DIRS - 1) / 2;

    localparam logic [PW-1:0]        X0_FX     = PW'(BALL_X0) << FRAC_BITS;
    localparam logic [PW-1:0]        Y0_FX     = PW'(BALL_Y0) << FRAC_BITS;
    localparam logic [PW-1:0]        DY_FX     = PW'(Y_STEP) << FRAC_BITS;
    localparam logic signed [XW-1:0] X_MAX     = XW'(639 << FRAC_BITS);
    localparam logic signed [XW-1:0] X_UNIT    = XW'(X_STEP_UNIT);
    localparam logic signed [XW-1:0] CTR       = XW'(CENTER);
    localparam logic [9:0]           GOAL      = 10'(GOAL_Y);
    localparam logic [DIR_W:0]       NDIRS     = (DIR_W + 1)'(NUM_DIRS);
    localparam logic [15:0]          WAIT_LAST = 16'(WAIT_TIMEOUT - 1);
    localparam logic [15:0]          HOLD_LAST = 16'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FLIGHT, S_RESULT} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    x_q, x_d, y_q, y_d;
    logic [DIR_W-1:0] shot_q, shot_d, kdir_q, kdir_d, rdir_q, rdir_d;
    logic             kcom_q, kcom_d, rvalid_q, rvalid_d, rsave_q, rsave_d;
    logic [15:0]      cnt_q, cnt_d;   // ARMED wait count / RESULT hold count

    logic                 shot_legal, keep_legal, commit_now;
    logic signed [XW-1:0] dir_off, x_step, x_next;

    // State and datapath registers; synchronous active-low reset.
    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            x_q      <= X0_FX;
            y_q      <= Y0_FX;
            shot_q   <= '0;
            kdir_q   <= '0;
            kcom_q   <= 1'b0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rsave_q  <= 1'b0;
            rdir_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            shot_q   <= shot_d;
            kdir_q   <= kdir_d;
            kcom_q   <= kcom_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rsave_q  <= rsave_d;
            rdir_q   <= rdir_d;
        end
    end

    // Next-state, keeper commit, flight stepping with lateral saturation.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        shot_d   = shot_q;
        kdir_d   = kdir_q;
        kcom_d   = kcom_q;
        cnt_d    = cnt_q;
        rvalid_d = 1'b0;
        rsave_d  = rsave_q;
        rdir_d   = rdir_q;

        shot_legal = bus.shoot_valid && ({1'b0, bus.shoot_dir} < NDIRS);
        keep_legal = bus.keeper_valid && ({1'b0, bus.keeper_dir} < NDIRS);
        commit_now = keep_legal && !kcom_q &&
                     (state_q == S_ARMED || state_q == S_FLIGHT);

        // Signed offset from the centre lane; even NUM_DIRS leans right.
        dir_off = $signed({{(XW-DIR_W){1'b0}}, shot_q}) - CTR;
        x_step  = dir_off * X_UNIT;
        x_next  = $signed({{(XW-PW){1'b0}}, x_q}) + x_step;

        if (commit_now) begin
            kcom_d = 1'b1;
            kdir_d = bus.keeper_dir;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (shot_legal) begin
                    shot_d  = bus.shoot_dir;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (bus.player_at_ball) begin
                    state_d = S_FLIGHT;
                    cnt_d   = '0;
                end else if (cnt_q == WAIT_LAST) begin
                    // Shooter never arrived: abandon the shot, ball untouched.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    kcom_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_FLIGHT: begin
                if (y_q[PW-1:FRAC_BITS] <= GOAL) begin
                    // Goal line reached: freeze position, keeper committing
                    // on this very edge still counts.
                    state_d  = S_RESULT;
                    cnt_d    = '0;
                    rvalid_d = 1'b1;
                    rdir_d   = shot_q;
                    rsave_d  = commit_now ? (bus.keeper_dir == shot_q)
                                          : (kcom_q && (kdir_q == shot_q));
                end else begin
                    if (x_next[XW-1])
                        x_d = '0;
                    else if (x_next > X_MAX)
                        x_d = X_MAX[PW-1:0];
                    else
                        x_d = x_next[PW-1:0];
                    y_d = y_q - DY_FX;
                end
            end
            S_RESULT: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    x_d     = X0_FX;
                    y_d     = Y0_FX;
                    kcom_d  = 1'b0;
                    kdir_d  = '0;
                    rsave_d = 1'b0;
                    rdir_d  = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.shoot_ready  = (state_q == S_IDLE);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.BallX        = x_q[PW-1:FRAC_BITS];
    assign bus.BallY        = y_q[PW-1:FRAC_BITS];
    assign bus.BallS        = 10'(BALL_SIZE);
    assign bus.result_valid = rvalid_q;
    assign bus.result_save  = rsave_q;
    assign bus.result_dir   = rdir_q;
endmodule

// File: tb/tb_ball_shot_engine.sv
// Bench for ball_shot_engine: directed scenarios plus randomized shots, with a
// scoreboard of expected results checked by an independent result monitor.
module tb_ball_shot_engine;
    localparam int ND = 5, DW = 3, FB = 4, X0 = 320, Y0 = 365, GOAL = 100;
    localparam int YS = 2, UNIT = 16, HOLD = 30, CTR = (ND - 1) / 2;

    logic frame_clk = 1'b0;
    logic Reset_n   = 1'b0;
    always #5 frame_clk = ~frame_clk;

    ball_shot_engine_if #(.DIR_W(DW)) bus();
    ball_shot_engine dut (.frame_clk(frame_clk), .Reset_n(Reset_n), .bus(bus));

    typedef struct {int x; int y; int save; int dir;} exp_t;
    exp_t sb_q[$];

    int checks = 0, errors = 0;
    int hold_n = 0;
    bit hold_on = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.shoot_valid = 1'b0;  bus.shoot_dir  = '0;
        bus.player_at_ball = 1'b0;
        bus.keeper_valid = 1'b0; bus.keeper_dir = '0;
    endtask

    // Frames of flight until the ball's pixel row is at or above the goal line.
    function automatic int flight_steps();
        return (Y0 - GOAL + YS - 1) / YS;
    endfunction

    // Lateral pixel after n frames of flight; the screen edge clamps.
    function automatic int x_after(input int s, input int n);
        int fx;
        fx = X0 * (1 << FB) + (s - CTR) * UNIT * n;
        if (fx < 0) fx = 0;
        if (fx > 639 * (1 << FB)) fx = 639 * (1 << FB);
        return fx / (1 << FB);
    endfunction

    // Result monitor: scoreboard pop on each pulse, then hold length and home.
    always @(negedge frame_clk) begin
        exp_t e;
        if (bus.result_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("res_x", bus.BallX, e.x);
                chk("res_y", bus.BallY, e.y);
                chk("res_save", bus.result_save, e.save);
                chk("res_dir", bus.result_dir, e.dir);
            end
            hold_n  = 1;
            hold_on = 1'b1;
        end else if (hold_on) begin
            if (bus.busy) hold_n++;
            else begin
                chk("hold_len", hold_n, HOLD);
                chk("home_x", bus.BallX, X0);
                chk("home_y", bus.BallY, Y0);
                hold_on = 1'b0;
            end
        end
    end

    // One shot. kj*/kd*: keeper request frame/dir after accept (-1 = none);
    // bj: frame of a stray shoot_valid; late_k: keeper dir = shot on the
    // goal-line edge; abort_at: FLIGHT frame at which reset is applied.
    task automatic do_shot(input int s, input int a, input int kj1, input int kd1,
                           input int kj2, input int kd2, input int bj,
                           input bit late_k, input bit trace, input int abort_at);
        int w, j, k, n, kwin;
        bit late_fire, late_done;
        exp_t e;
        w = 0;
        while (!bus.shoot_ready && w < 400) begin tick(); w++; end
        if (!bus.shoot_ready) begin chk("ready_wait", 0, 1); return; end
        bus.shoot_valid = 1'b1; bus.shoot_dir = DW'(s); bus.player_at_ball = 1'b0;
        tick();
        bus.shoot_valid = 1'b0;
        chk("accept_busy", bus.busy, 1);

        n = flight_steps();
        kwin = -1;
        if (kj1 > 0 && kd1 < ND) kwin = kd1;
        else if (kj2 > 0 && kd2 < ND) kwin = kd2;
        else if (late_k) kwin = s;
        if (abort_at < 0) begin
            e.x = x_after(s, n); e.y = Y0 - YS * n; e.save = (kwin == s); e.dir = s;
            sb_q.push_back(e);
        end

        late_fire = 1'b0; late_done = 1'b0;
        for (j = 1; j < 700; j++) begin
            bus.player_at_ball = (j > a);
            bus.keeper_valid = 1'b0;
            if (j == kj1) begin bus.keeper_valid = 1'b1; bus.keeper_dir = DW'(kd1); end
            if (j == kj2) begin bus.keeper_valid = 1'b1; bus.keeper_dir = DW'(kd2); end
            if (late_fire) begin
                bus.keeper_valid = 1'b1; bus.keeper_dir = DW'(s);
                late_fire = 1'b0; late_done = 1'b1;
            end
            bus.shoot_valid = (j == bj);
            bus.shoot_dir   = DW'($urandom_range(0, ND - 1));
            if (abort_at >= 0 && j == a + 1 + abort_at) Reset_n = 1'b0;
            tick();
            k = j - 1 - a;
            if (trace && k >= 0 && k <= n) begin
                chk("trace_y", bus.BallY, Y0 - YS * k);
                chk("trace_x", bus.BallX, x_after(s, k));
            end
            if (abort_at >= 0 && j == a + 1 + abort_at) begin
                chk("abort_x", bus.BallX, X0);
                chk("abort_y", bus.BallY, Y0);
                chk("abort_busy", bus.busy, 0);
                chk("abort_ready", bus.shoot_ready, 1);
                chk("abort_rv", bus.result_valid, 0);
                Reset_n = 1'b1;
                break;
            end
            if (late_k && !late_done && bus.BallY <= GOAL) late_fire = 1'b1;
            if (!bus.busy) break;
        end
        if (j >= 700) chk("shot_done_wait", 0, 1);
        idle_inputs();
    endtask

    initial begin
        int s, a, kj1, kd1, kj2, kd2, bj;
        idle_inputs();
        Reset_n = 1'b0;
        tick(); tick();
        chk("rst_x", bus.BallX, X0);
        chk("rst_y", bus.BallY, Y0);
        chk("rst_s", bus.BallS, 16);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.shoot_ready, 1);
        chk("rst_rv", bus.result_valid, 0);
        chk("rst_save", bus.result_save, 0);
        chk("rst_dir", bus.result_dir, 0);
        Reset_n = 1'b1;
        tick();

        // Out-of-range directions are dropped in IDLE.
        bus.shoot_valid = 1'b1; bus.shoot_dir = 3'd5;
        tick();
        chk("illegal5_busy", bus.busy, 0);
        bus.shoot_dir = 3'd7;
        tick();
        chk("illegal7_ready", bus.shoot_ready, 1);
        bus.shoot_valid = 1'b0;
        tick();

        // Centre shot, keeper left during flight, stray shot request in flight.
        do_shot(2, 0, 3, 0, -1, 0, 6, 1'b0, 1'b1, -1);
        tick(); tick(); tick();
        chk("no_second_shot", bus.busy, 0);

        // Left corner, keeper commits left while ARMED.
        do_shot(0, 2, 1, 0, -1, 0, -1, 1'b0, 1'b1, -1);
        // First keeper request wins.
        do_shot(0, 1, 1, 4, 2, 0, -1, 1'b0, 1'b0, -1);
        // Keeper commit on the goal-line edge still counts.
        do_shot(3, 0, -1, 0, -1, 0, -1, 1'b1, 1'b0, -1);

        // Shooter never arrives.
        bus.shoot_valid = 1'b1; bus.shoot_dir = 3'd1;
        tick();
        bus.shoot_valid = 1'b0;
        for (int f = 1; f <= 254; f++) tick();
        chk("to_busy_254", bus.busy, 1);
        tick();
        chk("to_idle", bus.busy, 0);
        chk("to_y", bus.BallY, Y0);
        chk("to_x", bus.BallX, X0);

        // Reset at flight frame 60.
        do_shot(2, 0, -1, 0, -1, 0, -1, 1'b0, 1'b0, 60);
        tick();

        // Randomized shots; keeper pokes in IDLE beforehand must be ignored.
        for (int r = 0; r < 16; r++) begin
            s   = $urandom_range(0, ND - 1);
            a   = $urandom_range(0, 20);
            kj1 = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(1, 3);
            kd1 = $urandom_range(0, 7);
            kj2 = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(4, 6);
            kd2 = $urandom_range(0, 7);
            bj  = ($urandom_range(0, 1) == 0) ? -1 : a + $urandom_range(2, 10);
            bus.keeper_valid = 1'b1; bus.keeper_dir = DW'(s);
            tick();
            bus.keeper_valid = 1'b0;
            do_shot(s, a, kj1, kd1, kj2, kd2, bj, 1'(($urandom_range(0, 1))),
                    1'b0, -1);
        end
        tick(); tick();
        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end
endmodule
